seven_seg_scanner: RTL
======================

# seven_seg_scanner

Time-multiplexed driver for a multi-digit common-cathode seven-segment display. Consumes per-digit 8-bit segment patterns (the output format of `hex_to_7seg`: bits 6:0 = g..a, bit 7 = dp), double-buffers them, and scans one digit at a time with a programmable dwell and an optional anti-ghosting blank gap. It sits directly downstream of one `hex_to_7seg` instance per digit and drives the board pins.

## Interface
Parameters:
- `DIGITS`, default 4: number of digits scanned. Legal range is 2..8.
- `DIV_BITS`, default 14: dwell per digit is 2^DIV_BITS cycles. At the 16 MHz `CLK`, the default gives about 977 Hz per digit.
- `BLANK_CYCLES`, default 16: length of the all-off gap between digits. Must be at least 1. Only used with `SCAN_BLANK_EN`.

Ports:
- `i_clk` input, 1 bit: clock. This is the board `CLK`.
- `i_rst_n` input, 1 bit: reset, synchronous, active-low.
- `i_segs` input, 8*DIGITS bits: frame of segment patterns. Digit k uses bits [8k+7:8k]. Digit 0 is the rightmost.
- `i_load` input, 1 bit: single-cycle strobe that captures `i_segs` into the pending buffer.
- `o_pending` output, 1 bit: pending buffer holds a frame that is not yet displayed.
- `o_ack` output, 1 bit: one-cycle pulse when a pending frame becomes active.
- `o_seg` output, 8 bits: segment drive, active-high, in {dp,g,f,e,d,c,b,a} order.
- `o_dig` output, DIGITS bits: one-hot digit enable, active-high.

## Operation
- Storage: an active frame register and a pending frame register, each 8*DIGITS bits, plus a pending-valid flag.
- State machine:
  - DISP: `o_dig` is one-hot at `idx`. `o_seg` equals the active frame slice `idx`.
  - BLANK: `o_dig` = 0 and `o_seg` = 0.
- Dwell counter: DIV_BITS wide. It counts up in DISP and is cleared when DISP is left.
- Transition at dwell terminal (counter = 2^DIV_BITS−1):
  - With `SCAN_BLANK_EN`: go to BLANK.
  - Without it: go straight to DISP with the next `idx`.
- Blank counter: counts BLANK_CYCLES cycles. The move to DISP with the next `idx` happens on the last of those cycles.
- Next `idx` is `idx`+1, wrapping DIGITS−1 → 0.
- Frame swap: happens only on the transition into DISP with `idx` = 0, and only if pending-valid is set. On that edge:
  - the active frame takes the pending frame,
  - pending-valid clears,
  - `o_ack` pulses.

  Swapping only at this point means a frame is never shown half-old, half-new.
- Load: `i_load` captures `i_segs` into the pending buffer and sets pending-valid.
  - If the buffer is already full, the new frame overwrites it (latest wins). There is no ack for the dropped frame.
- Load on a swap edge: the swap uses the old pending contents. The new load then becomes pending, so `o_pending` stays 1.
- Load with an empty buffer on a swap edge: the load goes to pending and is shown at the next wrap.
- Reset (any cycle, including mid-dwell or mid-blank) puts every register in its reset state:
  - `idx` = 0, state = DISP, both counters = 0,
  - active frame = 0, pending frame = 0, pending-valid = 0,
  - `o_ack` = 0, `o_pending` = 0, `o_seg` = 0, `o_dig` = 0.
- `i_load` is ignored while `i_rst_n` = 0.

## Timing
- All outputs are registered. `o_seg` and `o_dig` change on the same edge as the state.
- First active cycle after reset release: `o_dig` = 1 (digit 0), `o_seg` = 0.
- Dwell: DISP lasts exactly 2^DIV_BITS cycles per digit.
- Blank: BLANK lasts exactly BLANK_CYCLES cycles per gap.
- Frame period:
  - with `SCAN_BLANK_EN`: DIGITS*(2^DIV_BITS+BLANK_CYCLES) cycles,
  - without it: DIGITS*2^DIV_BITS cycles.
- Load latency: `i_load` sampled at edge t gives `o_pending` = 1 from t+1.
- Worst-case display latency is one frame period plus one digit slot.
- `o_ack` is high for exactly the first cycle of DISP with `idx` = 0 after a swap. In that same cycle, `o_seg` already shows the new frame's digit 0.
- `o_dig` is never more than one-hot. With blanking enabled, it is all-zero for every BLANK cycle.

## Configuration
- Macro: `SCAN_BLANK_EN`.
- Defined: the BLANK state and blank counter are present, and the anti-ghost gap is inserted between every pair of digits, including the wrap.
- Undefined: BLANK state and counter are not built and `BLANK_CYCLES` is ignored. Digits change on consecutive cycles.

## Test plan
Bench setup: DIGITS=4, DIV_BITS=2, BLANK_CYCLES=2, `SCAN_BLANK_EN` defined, so each digit slot is 6 cycles and the frame is 24 cycles.
1. Reset release with no load:
   - `o_dig` runs 0001 for 4 cycles, 0000 for 2, 0010 for 4, 0000 for 2, …, repeating every 24 cycles.
   - `o_seg` = 0 throughout; `o_ack` never pulses.
2. Load `i_segs` = 32'h5B4F_0666, driving a one-cycle `i_load` mid-digit-1:
   - `o_pending` = 1 on the next cycle.
   - At the next entry to digit 0: `o_ack` pulses, `o_seg` = 8'h66, `o_pending` = 0.
   - Then digit 1 shows 8'h06, digit 2 shows 8'h4F, digit 3 shows 8'h5B.
3. Two loads inside one frame (A, then B):
   - Exactly one `o_ack`; B is displayed and A never appears.
4. Load on the exact swap edge while frame A is pending:
   - A becomes active with `o_ack`; `o_pending` stays 1.
   - At the next wrap, B becomes active with a second `o_ack`.
5. `i_rst_n` = 0 for 1 cycle in the middle of digit 2 with a frame active:
   - Next cycle: all outputs 0 and `o_pending` = 0.
   - Then the scan restarts at digit 0 with a blank frame.
6. Rebuild without `SCAN_BLANK_EN`:
   - `o_dig` sequence is 0001×4, 0010×4, 0100×4, 1000×4, repeating every 16 cycles, with no all-zero cycles.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a common-cathode
// seven-segment display. Double-buffers a frame of per-digit patterns
// and scans one digit at a time with a 2^DIV_BITS-cycle dwell.
// Optional feature macro: SCAN_BLANK_EN. When it is defined, an all-off
// gap of BLANK_CYCLES cycles is inserted between digits.
module seven_seg_scanner #(
    parameter int DIGITS       = 4,
    parameter int DIV_BITS     = 14,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [8*DIGITS-1:0]   i_segs,
    input  logic                  i_load,
    output logic                  o_pending,
    output logic                  o_ack,
    output logic [7:0]            o_seg,
    output logic [DIGITS-1:0]     o_dig
);

    localparam int              IDX_W    = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    // Reject illegal parameter sets at elaboration.
    if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
        $error("seven_seg_scanner: DIGITS must be 2..8");
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank
        $error("seven_seg_scanner: BLANK_CYCLES must be at least 1");
    end

    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    nxt_idx;
    logic [IDX_W-1:0]    enter_idx;
    logic [DIV_BITS-1:0] dwell;
    logic [8*DIGITS-1:0] active;
    logic [8*DIGITS-1:0] pending;
    logic [8*DIGITS-1:0] next_active;
    logic                pend_vld;
    logic                dwell_end;
    logic                restart;
    logic                enter_disp;
    logic                swap;

`ifdef SCAN_BLANK_EN
    localparam int BCNT_W = $clog2(BLANK_CYCLES + 1);

    typedef enum logic {DISP, BLANK} state_t;

    state_t            state;
    logic [BCNT_W-1:0] bcnt;
    logic              blank_end;
`endif

    assign o_pending = pend_vld;

    // Decode the step taken at the next edge: whether DISP is (re)entered,
    // at which digit, and whether the pending frame is swapped in there.
    always_comb begin
        nxt_idx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        dwell_end = &dwell;
`ifdef SCAN_BLANK_EN
        // DISP with nothing lit only happens in the cycle after reset;
        // that edge is treated as the entry into digit 0 so its dwell is full.
        restart    = (state == DISP) && (o_dig == '0);
        blank_end  = (state == BLANK) && (bcnt == BCNT_W'(BLANK_CYCLES - 1));
        enter_disp = restart || blank_end;
`else
        restart    = (o_dig == '0);
        enter_disp = restart || dwell_end;
`endif
        enter_idx   = restart ? idx : nxt_idx;
        swap        = enter_disp && (enter_idx == '0) && pend_vld;
        next_active = swap ? pending : active;
    end

    // Scan state machine, frame buffers and registered pin drive.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            idx      <= '0;
            dwell    <= '0;
            active   <= '0;
            pending  <= '0;
            pend_vld <= 1'b0;
            o_ack    <= 1'b0;
            o_seg    <= '0;
            o_dig    <= '0;
`ifdef SCAN_BLANK_EN
            state    <= DISP;
            bcnt     <= '0;
`endif
        end else begin
            o_ack  <= swap;
            active <= next_active;

            // A load on the swap edge lands after the swap, so it stays pending.
            if (i_load) begin
                pending  <= i_segs;
                pend_vld <= 1'b1;
            end else if (swap) begin
                pend_vld <= 1'b0;
            end

            if (enter_disp) begin
                idx   <= enter_idx;
                dwell <= '0;
                o_dig <= DIGITS'(1) << enter_idx;
                o_seg <= next_active[{enter_idx, 3'b000} +: 8];
`ifdef SCAN_BLANK_EN
                state <= DISP;
                bcnt  <= '0;
`endif
            end
`ifdef SCAN_BLANK_EN
            else if (state == DISP) begin
                if (dwell_end) begin
                    state <= BLANK;
                    dwell <= '0;
                    bcnt  <= '0;
                    o_dig <= '0;
                    o_seg <= '0;
                end else begin
                    dwell <= dwell + 1'b1;
                end
            end else begin
                bcnt <= bcnt + 1'b1;
            end
`else
            else begin
                dwell <= dwell + 1'b1;
            end
`endif
        end
    end

endmodule
